// File: rtl/cache_pkg.sv
// Shared constants, entry layout and write-mask helper for the 2-way, 512-set tag array controller.
package cache_pkg;
  localparam int ADDR_W    = 32;
  localparam int IDX_W     = 9;
  localparam int OFF_W     = 6;
  localparam int TAG_W     = 17;
  localparam int WAY_W     = 19;
  localparam int LINE_W    = 2 * WAY_W;
  localparam int VLD_BIT   = 18;
  localparam int DIRTY_BIT = 17;
  localparam int TAG_LSB   = 0;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // Way 1 occupies the upper half of the array word.
  function automatic logic [LINE_W-1:0] way_wmask(input logic way);
    way_wmask = way ? {{WAY_W{1'b1}}, {WAY_W{1'b0}}} : {{WAY_W{1'b0}}, {WAY_W{1'b1}}};
  endfunction
endpackage

// File: rtl/cache_tag_hitcmp.sv
// Single-way tag compare: an entry hits when it is valid and its stored tag matches.
module cache_tag_hitcmp
  import cache_pkg::*;
(
  input  logic [WAY_W-1:0] entry,
  input  logic [TAG_W-1:0] tag,
  output logic             hit
);
  assign hit = entry[VLD_BIT] && (entry[TAG_LSB +: TAG_W] == tag);
endmodule

// File: rtl/cache_tag_ctrl.sv
// Tag array initiator: post-reset clear sweep, 2-stage lookup (read, compare) and tag updates.
// Optional TAG_BYPASS_EN forwards a same-cycle, same-index update into the lookup instead of stalling.
module cache_tag_ctrl
  import cache_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  output logic                init_done,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic                resp_way,
  output logic                resp_dirty,
  output logic [TAG_W-1:0]    resp_vtag,
  output logic                resp_vvalid,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [IDX_W-1:0]    upd_index,
  input  logic                upd_way,
  input  logic [WAY_W-1:0]    upd_entry,
  output logic                ta_ce,
  output logic                ta_we,
  output logic [IDX_W-1:0]    ta_waddr,
  output logic [IDX_W-1:0]    ta_raddr,
  output logic [2*WAY_W-1:0]  ta_din,
  output logic [2*WAY_W-1:0]  ta_wmask,
  input  logic [2*WAY_W-1:0]  ta_dout
);
  ctrl_state_e      state_q, state_d;
  logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic             rr_q, rr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
`ifdef TAG_BYPASS_EN
  logic             s1_byp_q, s1_byp_d;
  logic             s1_byp_way_q, s1_byp_way_d;
  logic [WAY_W-1:0] s1_byp_entry_q, s1_byp_entry_d;
`endif

  logic             run_s, sweep_s, hazard_s, accept_s, upd_fire_s;
  logic [IDX_W-1:0] req_idx_s;
  logic [TAG_W-1:0] req_tag_s;
  logic [WAY_W-1:0] ent0_s, ent1_s;
  tag_entry_t       sel_ent_s;
  logic             hit0_s, hit1_s, both_valid_s, miss_s, way_s;
  logic             unused_addr_s;

  assign req_idx_s     = req_addr[OFF_W +: IDX_W];
  assign req_tag_s     = req_addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_s = ^req_addr[OFF_W-1:0];
  assign run_s         = (state_q == ST_RUN);
  // Keep the array pins quiet while reset is held, even though the FSM already sits in INIT.
  assign sweep_s       = (state_q == ST_INIT) && reset_n;
  assign init_done     = run_s;
  assign upd_ready     = run_s;
  assign upd_fire_s    = upd_valid && run_s;
`ifdef TAG_BYPASS_EN
  assign hazard_s      = 1'b0;
`else
  assign hazard_s      = upd_valid && (upd_index == req_idx_s);
`endif
  assign req_ready     = run_s && !hazard_s;
  assign accept_s      = req_valid && req_ready;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // FSM next state: one pass over every set, then lookups forever
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    case (state_q)
      ST_INIT: begin
        sweep_cnt_d = sweep_cnt_q + IDX_W'(1);
        if (sweep_cnt_q == {IDX_W{1'b1}}) state_d = ST_RUN;
        else                              state_d = ST_INIT;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM outputs: array pin drive for sweep, lookup read and update write
  always_comb begin
    ta_ce    = 1'b0;
    ta_we    = 1'b0;
    ta_waddr = '0;
    ta_raddr = '0;
    ta_din   = '0;
    ta_wmask = '0;
    case (state_q)
      ST_INIT: begin
        if (sweep_s) begin
          ta_ce    = 1'b1;
          ta_we    = 1'b1;
          ta_waddr = sweep_cnt_q;
          ta_wmask = '1;
        end else begin
          ta_ce    = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          ta_ce    = 1'b1;
          ta_raddr = req_idx_s;
        end else begin
          ta_raddr = '0;
        end
        if (upd_fire_s) begin
          ta_ce    = 1'b1;
          ta_we    = 1'b1;
          ta_waddr = upd_index;
          ta_din   = {upd_entry, upd_entry};
          ta_wmask = way_wmask(upd_way);
        end else begin
          ta_we    = 1'b0;
        end
      end
      default: ta_ce = 1'b0;
    endcase
  end

  // Stage1 capture of the accepted lookup (and any forwarded update)
  always_comb begin
    s1_valid_d = accept_s;
    if (accept_s) s1_tag_d = req_tag_s;
    else          s1_tag_d = s1_tag_q;
`ifdef TAG_BYPASS_EN
    s1_byp_d       = accept_s && upd_fire_s && (upd_index == req_idx_s);
    s1_byp_way_d   = upd_way;
    s1_byp_entry_d = upd_entry;
`endif
  end

  // Stage1 way entries, with the forwarded update laid over the written way
  always_comb begin
    ent0_s = ta_dout[WAY_W-1:0];
    ent1_s = ta_dout[2*WAY_W-1:WAY_W];
`ifdef TAG_BYPASS_EN
    if (s1_byp_q && !s1_byp_way_q) ent0_s = s1_byp_entry_q;
    else if (s1_byp_q)             ent1_s = s1_byp_entry_q;
    else                           ent0_s = ta_dout[WAY_W-1:0];
`endif
  end

  cache_tag_hitcmp u_hit0 (.entry(ent0_s), .tag(s1_tag_q), .hit(hit0_s));
  cache_tag_hitcmp u_hit1 (.entry(ent1_s), .tag(s1_tag_q), .hit(hit1_s));

  // Hit/victim selection and response drive; way0 wins a double hit
  always_comb begin
    both_valid_s = ent0_s[VLD_BIT] && ent1_s[VLD_BIT];
    miss_s       = !(hit0_s || hit1_s);
    if (hit0_s)                way_s = 1'b0;
    else if (hit1_s)           way_s = 1'b1;
    else if (!ent0_s[VLD_BIT]) way_s = 1'b0;
    else if (!ent1_s[VLD_BIT]) way_s = 1'b1;
    else                       way_s = rr_q;
    sel_ent_s = way_s ? tag_entry_t'(ent1_s) : tag_entry_t'(ent0_s);
    if (s1_valid_q && miss_s && both_valid_s) rr_d = !rr_q;
    else                                      rr_d = rr_q;
    resp_valid  = s1_valid_q;
    resp_hit    = s1_valid_q && !miss_s;
    resp_way    = s1_valid_q && way_s;
    resp_dirty  = s1_valid_q && sel_ent_s.dirty;
    resp_vvalid = s1_valid_q && sel_ent_s.valid;
    if (s1_valid_q) resp_vtag = sel_ent_s.tag;
    else            resp_vtag = '0;
  end

  // Datapath registers: sweep counter, victim pointer, stage1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sweep_cnt_q    <= '0;
      rr_q           <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_tag_q       <= '0;
`ifdef TAG_BYPASS_EN
      s1_byp_q       <= 1'b0;
      s1_byp_way_q   <= 1'b0;
      s1_byp_entry_q <= '0;
`endif
    end else begin
      sweep_cnt_q    <= sweep_cnt_d;
      rr_q           <= rr_d;
      s1_valid_q     <= s1_valid_d;
      s1_tag_q       <= s1_tag_d;
`ifdef TAG_BYPASS_EN
      s1_byp_q       <= s1_byp_d;
      s1_byp_way_q   <= s1_byp_way_d;
      s1_byp_entry_q <= s1_byp_entry_d;
`endif
    end
  end
endmodule
